// File: rtl/time_pkg.sv
// Shared definitions for the time-frame receive path and the time display.
// Frame layout: header, hour, min, sec, checksum (MSB first).
package time_pkg;

    localparam logic [7:0]  HEADER      = 8'hCC;
    localparam logic [19:0] TIMEOUT_CYC = 20'd5000;

    localparam int H_MSB   = 31;
    localparam int H_LSB   = 24;
    localparam int M_MSB   = 23;
    localparam int M_LSB   = 16;
    localparam int S_MSB   = 15;
    localparam int S_LSB   = 8;
    localparam int CHK_MSB = 7;
    localparam int CHK_LSB = 0;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] SEC_MAX  = 8'd59;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } rx_state_e;

    function automatic logic [7:0] calc_chk(input logic [7:0] hour,
                                            input logic [7:0] min,
                                            input logic [7:0] sec);
        return hour ^ min ^ sec;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/frame_check.sv
// Combinational validation of a 32-bit time payload: XOR checksum plus
// hour/min/sec range limits.
module frame_check
    import time_pkg::*;
(
    input  logic [31:0] payload,
    output logic        ok
);

    logic [7:0] hour_s;
    logic [7:0] min_s;
    logic [7:0] sec_s;
    logic [7:0] chk_s;

    assign hour_s = payload[H_MSB:H_LSB];
    assign min_s  = payload[M_MSB:M_LSB];
    assign sec_s  = payload[S_MSB:S_LSB];
    assign chk_s  = payload[CHK_MSB:CHK_LSB];

    // Accept only a consistent checksum with every field inside its range
    always_comb begin
        ok = 1'b0;
        if ((chk_s == calc_chk(hour_s, min_s, sec_s)) &&
            (hour_s <= HOUR_MAX) && (min_s <= MIN_MAX) && (sec_s <= SEC_MAX)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
    end

endmodule

// File: rtl/time_frame_rx.sv
// Serial time-frame receiver: hunts for the sync byte, collects 32 payload
// bits, validates them and holds the last good frame for the display.
module time_frame_rx
    import time_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_vld,
    output logic [39:0] dat_o,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    rx_state_e   state_r;
    rx_state_e   state_nxt_s;
    logic [7:0]  hdr_sr_r;
    logic [7:0]  hdr_nxt_s;
    logic [31:0] pay_sr_r;
    logic [31:0] pay_nxt_s;
    logic [4:0]  bit_cnt_r;
    logic [4:0]  bit_cnt_nxt_s;
    logic [19:0] to_cnt_r;
    logic [19:0] to_cnt_nxt_s;
    logic [39:0] dat_r;
    logic [39:0] dat_nxt_s;
    logic        ok_r;
    logic        ok_nxt_s;
    logic        err_r;
    logic        err_nxt_s;
    logic [7:0]  err_cnt_r;
    logic [7:0]  err_cnt_nxt_s;
    logic        chk_ok_s;
    logic [7:0]  hdr_shift_s;

    frame_check u_frame_check (
        .payload (pay_sr_r),
        .ok      (chk_ok_s)
    );

    assign hdr_shift_s = {hdr_sr_r[6:0], bit_in};

    // Next-state and next-datapath decode
    always_comb begin
        state_nxt_s   = state_r;
        hdr_nxt_s     = hdr_sr_r;
        pay_nxt_s     = pay_sr_r;
        bit_cnt_nxt_s = bit_cnt_r;
        to_cnt_nxt_s  = to_cnt_r;
        dat_nxt_s     = dat_r;
        ok_nxt_s      = 1'b0;
        err_nxt_s     = 1'b0;
        err_cnt_nxt_s = err_cnt_r;

        case (state_r)
            HUNT: begin
                if (bit_vld) begin
                    hdr_nxt_s = hdr_shift_s;
                    if (hdr_shift_s == HEADER) begin
                        state_nxt_s   = COLLECT;
                        bit_cnt_nxt_s = 5'd0;
                        to_cnt_nxt_s  = 20'd0;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            COLLECT: begin
                if (bit_vld) begin
                    pay_nxt_s    = {pay_sr_r[30:0], bit_in};
                    to_cnt_nxt_s = 20'd0;
                    if (bit_cnt_r == 5'd31) begin
                        state_nxt_s   = CHECK;
                        bit_cnt_nxt_s = 5'd0;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                    end
                end else if (to_cnt_r == (TIMEOUT_CYC - 20'd1)) begin
                    // Link went quiet mid-frame: drop it and resynchronise
                    state_nxt_s   = HUNT;
                    hdr_nxt_s     = 8'd0;
                    to_cnt_nxt_s  = 20'd0;
                    bit_cnt_nxt_s = 5'd0;
                    err_nxt_s     = 1'b1;
                    err_cnt_nxt_s = sat_inc8(err_cnt_r);
                end else begin
                    to_cnt_nxt_s = to_cnt_r + 20'd1;
                end
            end
            CHECK: begin
                state_nxt_s = HUNT;
                if (chk_ok_s) begin
                    dat_nxt_s = {HEADER, pay_sr_r};
                    ok_nxt_s  = 1'b1;
                end else begin
                    err_nxt_s     = 1'b1;
                    err_cnt_nxt_s = sat_inc8(err_cnt_r);
                end
                // A bit arriving during CHECK starts the next header search
                if (bit_vld) begin
                    hdr_nxt_s = {7'b0000000, bit_in};
                end else begin
                    hdr_nxt_s = 8'd0;
                end
            end
            default: begin
                state_nxt_s = HUNT;
                hdr_nxt_s   = 8'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_sr_r  <= 8'd0;
            pay_sr_r  <= 32'd0;
            bit_cnt_r <= 5'd0;
            to_cnt_r  <= 20'd0;
            dat_r     <= 40'd0;
            ok_r      <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            hdr_sr_r  <= hdr_nxt_s;
            pay_sr_r  <= pay_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            to_cnt_r  <= to_cnt_nxt_s;
            dat_r     <= dat_nxt_s;
            ok_r      <= ok_nxt_s;
            err_r     <= err_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign dat_o     = dat_r;
    assign frame_ok  = ok_r;
    assign frame_err = err_r;
    assign err_cnt   = err_cnt_r;

endmodule
